// File: rtl/mem_tiled_pkg.sv
// Shared defaults and derived-size helpers for the tiled two-port memory.
// The top-level header explains the MEM_TILED_RDCLR_EN build option.
package mem_tiled_pkg;

    localparam int unsigned DEF_DATA_W     = 16;
    localparam int unsigned DEF_N_WORDS    = 8192;
    localparam int unsigned DEF_TILE_WORDS = 2048;

    localparam int unsigned N_TILES = DEF_N_WORDS / DEF_TILE_WORDS;
    localparam int unsigned IDX_W   = $clog2(DEF_N_WORDS);
    localparam int unsigned TILE_AW = $clog2(DEF_TILE_WORDS);

    function automatic int unsigned addr_w_f(input int unsigned n_words,
                                             input int unsigned data_w);
        return $clog2(n_words * data_w / 8);
    endfunction

    // A single tile still needs a select register that is one bit wide.
    function automatic int unsigned sel_w_f(input int unsigned n_tiles);
        return (n_tiles > 1) ? $clog2(n_tiles) : 1;
    endfunction

endpackage

// File: rtl/mem_2p_tile.sv
// One TILE_WORDS x DATA_W storage tile with a synchronous, read-first port.
module mem_2p_tile
    import mem_tiled_pkg::*;
#(
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned TILE_WORDS = DEF_TILE_WORDS,
    parameter int unsigned AW         = $clog2(TILE_WORDS)
) (
    input  logic              clk,
    input  logic              en_w,
    input  logic              en_r,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] mem [TILE_WORDS];

    // Both statements sample mem before the edge, so a colliding read sees old data.
    always_ff @(posedge clk) begin
        if (en_w) begin
            mem[addr] <= din;
        end
        if (en_r) begin
            dout <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_2p_tiled.sv
// Tiled single-address memory with synchronous read (1-cycle latency, read-first).
// Build option MEM_TILED_RDCLR_EN: data_out clears to 0 on every edge with r_en=0.
module mem_2p_tiled
    import mem_tiled_pkg::*;
#(
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned N_WORDS    = DEF_N_WORDS,
    parameter int unsigned TILE_WORDS = DEF_TILE_WORDS,
    parameter int unsigned ADDR_W     = addr_w_f(N_WORDS, DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              w_en,
    input  logic              r_en,
    input  logic [DATA_W-1:0] data_in,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data_out
);

    localparam int unsigned TILES    = N_WORDS / TILE_WORDS;
    localparam int unsigned IDX_BITS = $clog2(N_WORDS);
    localparam int unsigned OFF_BITS = $clog2(TILE_WORDS);
    localparam int unsigned SEL_BITS = sel_w_f(TILES);

    logic [IDX_BITS-1:0] idx;
    logic [OFF_BITS-1:0] offset;
    logic [SEL_BITS-1:0] tile_sel;
    logic [SEL_BITS-1:0] sel_q;
    logic                out_vld;
    logic                wr_ok;
    logic                rd_ok;
    logic [DATA_W-1:0]   tile_dout [TILES];

    assign idx    = addr[IDX_BITS-1:0];
    assign offset = idx[OFF_BITS-1:0];
    assign wr_ok  = w_en & ~rst;
    assign rd_ok  = r_en & ~rst;

    generate
        if (TILES > 1) begin : g_sel
            assign tile_sel = idx[IDX_BITS-1:OFF_BITS];
        end else begin : g_sel_one
            assign tile_sel = '0;
        end

        if (ADDR_W > IDX_BITS) begin : g_addr_hi
            logic unused_addr_hi;
            assign unused_addr_hi = ^addr[ADDR_W-1:IDX_BITS];
        end

        for (genvar t = 0; t < TILES; t++) begin : g_tile
            logic hit;
            assign hit = (tile_sel == SEL_BITS'(t));

            mem_2p_tile #(
                .DATA_W    (DATA_W),
                .TILE_WORDS(TILE_WORDS),
                .AW        (OFF_BITS)
            ) u_tile (
                .clk (clk),
                .en_w(wr_ok & hit),
                .en_r(rd_ok & hit),
                .addr(offset),
                .din (data_in),
                .dout(tile_dout[t])
            );
        end
    endgenerate

    // Tile select and a valid flag are registered on the read edge; the tile
    // dout registers hold the data, so the mux output behaves as the output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q   <= '0;
            out_vld <= 1'b0;
        end else if (r_en) begin
            sel_q   <= tile_sel;
            out_vld <= 1'b1;
        end
`ifdef MEM_TILED_RDCLR_EN
        else begin
            out_vld <= 1'b0;
        end
`else
`endif
    end

    assign data_out = out_vld ? tile_dout[sel_q] : '0;

endmodule

// File: tb/tb_mem_2p_tiled.sv
// Scoreboard bench for mem_2p_tiled: stimulus pushes expected read data, a monitor checks it.
module tb_mem_2p_tiled;

    localparam int unsigned DW = 16;
    localparam int unsigned NW = 8192;
    localparam int unsigned AW = 14;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          w_en = 1'b0;
    logic          r_en = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] data_out;

    int n_assert = 0;
    int n_fail   = 0;
    bit mon_en   = 1'b0;

    logic [DW-1:0] model   [NW];
    bit            written [NW];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] last_exp = '0;

    mem_2p_tiled #(
        .DATA_W    (16),
        .N_WORDS   (8192),
        .TILE_WORDS(2048),
        .ADDR_W    (14)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .w_en    (w_en),
        .r_en    (r_en),
        .data_in (data_in),
        .addr    (addr),
        .data_out(data_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: data_out=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // One bus cycle: drive on the falling edge, record the expectation, wait for the rising edge.
    task automatic op(input bit w, input bit r, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int unsigned i;
        i = int'(a) % NW;
        @(negedge clk);
        w_en    = w;
        r_en    = r;
        addr    = a;
        data_in = d;
        if (r) exp_q.push_back(model[i]);
        if (w) begin
            model[i]   = d;
            written[i] = 1'b1;
        end
        @(posedge clk);
    endtask

    always @(posedge rst) last_exp = '0;

    always @(posedge clk) begin : monitor
        bit rd;
        logic [DW-1:0] e;
        if (mon_en) begin
            rd = r_en && !rst;
            #1;
            if (rd) begin
                if (exp_q.size() == 0) begin
                    n_assert++;
                    n_fail++;
                    $display("FAIL sb_underflow: read seen with empty queue at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    check("read_data", data_out, e);
                    last_exp = e;
                end
            end else begin
`ifdef MEM_TILED_RDCLR_EN
                check("idle_clear", data_out, '0);
`else
                check("idle_hold", data_out, last_exp);
`endif
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] pool [8];
        logic [AW-1:0] a;
        int unsigned   idx;
        bit            w, r;

        pool = '{14'd0, 14'd2047, 14'd2048, 14'd4095, 14'd4096, 14'd6143, 14'd6144, 14'd8191};

        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 check("reset_state", data_out, '0);
        @(negedge clk);
        rst    = 1'b0;
        mon_en = 1'b1;

        for (int i = 0; i < 16; i++) op(1'b1, 1'b0, AW'(i), DW'(32 + i));
        for (int i = 0; i < 16; i++) op(1'b0, 1'b1, AW'(i), '0);
        for (int i = 0; i < 16; i++) op(1'b0, 1'b0, AW'(i), DW'($urandom));

        op(1'b1, 1'b0, 14'd2047, 16'hAAAA);
        op(1'b1, 1'b0, 14'd2048, 16'h5555);
        op(1'b1, 1'b0, 14'd8191, 16'h1234);
        for (int i = 0; i < 8; i++) op(1'b0, 1'b1, (i % 2 == 0) ? 14'd2047 : 14'd2048, '0);
        op(1'b0, 1'b1, 14'd8191, '0);

        op(1'b1, 1'b0, 14'd5, 16'h0011);
        op(1'b1, 1'b1, 14'd5, 16'h0022);
        op(1'b0, 1'b1, 14'd5, '0);

        op(1'b1, 1'b0, 14'd10 | 14'h2000, 16'h7777);
        op(1'b0, 1'b1, 14'd10, '0);

        for (int n = 0; n < 400; n++) begin
            idx = ($urandom_range(0, 3) != 0) ? int'(pool[$urandom_range(0, 7)]) : $urandom_range(0, NW - 1);
            a   = AW'(idx);
            a[AW-1] = 1'($urandom_range(0, 1));
            w   = 1'($urandom_range(0, 1));
            r   = 1'($urandom_range(0, 1)) && written[idx];
            op(w, r, a, DW'($urandom));
        end

        op(1'b1, 1'b0, 14'd3, 16'd35);
        op(1'b0, 1'b1, 14'd3, '0);
        #3;
        rst  = 1'b1;
        r_en = 1'b0;
        w_en = 1'b0;
        #1 check("rst_async_clear", data_out, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        op(1'b0, 1'b0, 14'd3, '0);
        op(1'b0, 1'b1, 14'd3, '0);

        op(1'b0, 1'b0, '0, '0);
        op(1'b0, 1'b0, '0, '0);
        #2;
        n_assert++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d reads outstanding, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
